// File: rtl/fetch_unit.sv
// Instruction fetch unit and single-port memory arbiter: owns the PC, feeds decode through a
// valid/ready register slice and lends the memory port to the load/store path for one cycle.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LS    = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic              fetch_fire;

    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // S_GAP hands the port back to fetch for a cycle so back-to-back accesses cannot starve it.
    always_comb begin
        state_d      = state_q;
        mem_addr     = pc;
        mem_en_write = 1'b0;
        mem_wdata    = '0;
        ls_done      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (ls_req) begin
                    state_d = S_LS;
                end
            end
            S_LS: begin
                state_d      = S_GAP;
                mem_addr     = ls_addr;
                mem_en_write = ls_we;
                mem_wdata    = ls_wdata;
            end
            S_GAP: begin
                state_d = S_FETCH;
                ls_done = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Handshake: a word moves to decode on a cycle where instr_valid && instr_ready; while
    // instr_valid is high and instr_ready low, instr/instr_pc hold. Redirect drops the word.
    assign fetch_fire = (state_q != S_LS) && !redirect && (!instr_valid || instr_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            ls_rdata    <= '0;
        end else begin
            if (redirect) begin
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
            end else if (fetch_fire) begin
                instr       <= mem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + ADDR_W'(1);
            end else if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end
            // The load/store access completes regardless of a redirect in the same cycle.
            if (state_q == S_LS && !ls_we) begin
                ls_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random fetch/redirect/load/store traffic,
// checked by a negedge monitor against a program-order fetch model and a load/store queue.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_en_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic [15:0] ls_rdata;
  logic        ls_done;
  logic [1:0]  dbg_state;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_en_write(mem_en_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:65535];
  initial for (int a = 0; a < 65536; a++) mem[a] = 16'(a) + 16'hA000;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_en_write) mem[mem_addr] <= mem_wdata;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          issue;
  } ls_t;

  ls_t         ls_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] store_ref [logic [15:0]];
  logic [15:0] exp_pc  = RESET_PC;
  logic [15:0] last_ld = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    if (store_ref.exists(a)) return store_ref[a];
    return a + 16'hA000;
  endfunction

  // ---------------- monitor ----------------
  logic        prev_reset    = 1'b0;
  logic        prev_redirect = 1'b0;
  logic        prev_stall    = 1'b0;
  logic [15:0] prev_instr    = '0;
  logic [15:0] prev_ipc      = '0;

  always @(negedge clk) begin
    ls_t         e;
    logic [15:0] ev;
    if (reset) begin
      ls_q.delete();
      exp_q.delete();
      last_ld = 16'h0000;
      exp_pc  = RESET_PC;
    end else begin
      if (prev_reset) begin
        check("post_reset_valid", instr_valid, 0);
        check("post_reset_done", ls_done, 0);
        check("post_reset_we", mem_en_write, 0);
        check("post_reset_rdata", ls_rdata, 0);
        check("post_reset_pc", mem_addr, RESET_PC);
      end
      if (prev_redirect) begin
        check("redirect_flush", instr_valid, 0);
      end else if (prev_stall) begin
        check("stall_valid", instr_valid, 1);
        check("stall_instr", instr, prev_instr);
        check("stall_pc", instr_pc, prev_ipc);
      end
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (instr_valid && instr_ready) begin
        check("fetch_pc", instr_pc, exp_pc);
        check("fetch_instr", instr, ref_word(exp_pc));
        exp_pc = exp_pc + 16'd1;
      end

      if (ls_q.size() > 0 && cyc == ls_q[0].issue + 1) begin
        check("ls_we", mem_en_write, ls_q[0].we);
        check("ls_addr", mem_addr, ls_q[0].addr);
        if (ls_q[0].we) check("ls_wdata", mem_wdata, ls_q[0].wdata);
      end else if (mem_en_write) begin
        check("spurious_write", mem_en_write, 0);
      end
      if (ls_done) begin
        if (ls_q.size() == 0) begin
          check("spurious_done", ls_done, 0);
        end else begin
          e  = ls_q.pop_front();
          ev = exp_q.pop_front();
          check("ls_latency", 32'(cyc - e.issue), 2);
          if (e.we) begin
            check("store_rdata_hold", ls_rdata, last_ld);
          end else begin
            check("load_rdata", ls_rdata, ev);
            last_ld = ev;
          end
        end
      end else if (ls_q.size() > 0 && cyc >= ls_q[0].issue + 2) begin
        check("ls_done_missing", ls_done, 1);
        void'(ls_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
    prev_reset    = reset;
    prev_redirect = redirect && !reset;
    prev_stall    = !reset && !redirect && instr_valid && !instr_ready;
    prev_instr    = instr;
    prev_ipc      = instr_pc;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] pick_pc();
    if ($urandom_range(0, 9) == 0) return 16'hFFF0 + 16'($urandom_range(0, 15));
    return 16'($urandom_range(0, 16'h3FFF));
  endfunction

  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    if (rnd) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = pick_pc();
    end else begin
      redirect = 1'b0;
    end
  endtask

  task automatic push_ls(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    ls_t e;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.issue = cyc;
    ls_q.push_back(e);
    if (we) begin
      store_ref[addr] = wdata;
      exp_q.push_back(16'h0000);
    end else begin
      exp_q.push_back(ref_word(addr));
    end
  endtask

  task automatic do_ls(input bit rnd, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bit done;
    step(rnd);
    ls_req   = 1'b1;
    ls_we    = we;
    ls_addr  = addr;
    ls_wdata = wdata;
    push_ls(we, addr, wdata);
    done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ls_done) begin
        done = 1'b1;
        break;
      end
      step(rnd);
    end
    if (!done) check("ls_done_timeout", 0, 1);
    step(rnd);
    ls_req = 1'b0;
    ls_we  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ls_req      = 1'b0;
    ls_we       = 1'b0;
    ls_addr     = '0;
    ls_wdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: first fetch latency and in-order stream from RESET_PC
    @(negedge clk);
    check("first_cycle_valid", instr_valid, 0);
    step(0);
    @(negedge clk);
    check("first_valid", instr_valid, 1);
    check("first_instr", instr, 16'hA000);
    check("first_pc", instr_pc, 16'h0000);

    // 2: three-cycle decode stall on A001
    step(0);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_hold_instr", instr, 16'hA001);
      check("stall_no_write", mem_en_write, 0);
      if (k < 2) step(0);
    end
    step(0);
    instr_ready = 1'b1;

    // 3: redirect to 0x0100 while instr_pc=5 is presented
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 16'd4) break;
      step(0);
    end
    step(0);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step(0);
    @(negedge clk);
    check("redir_gap_valid", instr_valid, 0);
    step(0);
    @(negedge clk);
    check("redir_valid", instr_valid, 1);
    check("redir_pc", instr_pc, 16'h0100);
    check("redir_instr", instr, 16'hA100);

    // 4: store then load back
    do_ls(0, 1'b1, 16'h8000, 16'hBEEF);
    do_ls(0, 1'b0, 16'h8000, 16'h0000);

    // 5: PC wraps past 0xFFFF
    step(0);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    repeat (5) step(0);

    // 6: reset in the S_LS cycle of a store, with a simultaneous redirect
    step(0);
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 16'h9000;
    ls_wdata = 16'h1234;
    push_ls(1'b1, 16'h9000, 16'h1234);
    step(0);
    reset       = 1'b1;
    ls_req      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    step(0);
    reset = 1'b0;
    repeat (4) step(0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        do_ls(1, 1'($urandom_range(0, 1)), 16'h8000 + 16'($urandom_range(0, 15)), 16'($urandom));
      end else begin
        step(1);
      end
    end
    step(0);
    instr_ready = 1'b1;
    repeat (6) step(0);
    @(negedge clk);
    check("ls_queue_drained", ls_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
